spi_dac_tx: RTL and testbench



---
 rtl/dac_pkg.sv | 20 ++
 rtl/sample_fifo.sv | 59 +++++
 rtl/spi_dac_tx.sv | 139 +++++++++++++
 tb/tb_spi_dac_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared types and constants for the serial DAC transmitter
package dac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        LATCH
    } state_t;

    // Write command, unbuffered, 1x gain, output active.
    localparam logic [3:0] DAC_CFG    = 4'b0011;
    localparam int         FRAME_BITS = 16;

    function automatic logic [FRAME_BITS-1:0] dac_frame(input logic [7:0] sample);
        return {DAC_CFG, sample, 4'b0000};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - small synchronous sample buffer with registered count
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // Flags come straight from the count register, so a pop never frees a slot in the same cycle.
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_dac_tx.sv
// rtl/spi_dac_tx.sv - buffers 8-bit samples and shifts them out as 16-bit SPI DAC write frames
module spi_dac_tx
    import dac_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       dac_cs_n,
    output logic       dac_sclk,
    output logic       dac_mosi,
    output logic       dac_ldac_n,
    output logic       busy,
    output logic       underrun
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    state_t                  state_q;
    logic [7:0]              div_q;
    logic                    phase_q;
    logic [3:0]              bit_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic                    cs_n_q;
    logic                    sclk_q;
    logic                    mosi_q;
    logic                    ldac_n_q;
    logic                    busy_q;
    logic                    underrun_q;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [7:0]              fifo_rdata;
    logic                    pop;
    logic                    div_done;
    logic                    frame_active;

    assign in_ready     = !fifo_full;
    assign pop          = (state_q == IDLE) && !fifo_empty;
    assign div_done     = (div_q == DIV_LAST);
    assign frame_active = (state_q == SETUP) || (state_q == SHIFT);

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_valid && in_ready),
        .pop_i   (pop),
        .wdata_i (in_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Pin registers follow the state one cycle late, which keeps every pin
    // aligned to the same edge and gives the push-to-cs_n latency of two cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            div_q      <= '0;
            phase_q    <= 1'b0;
            bit_q      <= '0;
            shift_q    <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ldac_n_q   <= 1'b1;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cs_n_q   <= !frame_active;
            sclk_q   <= (state_q == SHIFT) && phase_q;
            mosi_q   <= frame_active && shift_q[FRAME_BITS-1];
            ldac_n_q <= (state_q != LATCH);
            busy_q   <= (state_q != IDLE);
            div_q    <= div_done ? '0 : div_q + 8'd1;

            case (state_q)
                IDLE: begin
                    div_q <= '0;
                    if (pop) begin
                        shift_q <= dac_frame(fifo_rdata);
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_done) begin
                        state_q <= SHIFT;
                        phase_q <= 1'b0;
                        bit_q   <= '0;
                    end
                end
                SHIFT: begin
                    // Data advances only when a high half ends, i.e. at the start of the next low half.
                    if (div_done) begin
                        phase_q <= !phase_q;
                        if (phase_q) begin
                            if (bit_q == BIT_LAST) begin
                                state_q <= GAP;
                            end else begin
                                bit_q   <= bit_q + 4'd1;
                                shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                            end
                        end
                    end
                end
                GAP: begin
                    if (div_done) begin
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    if (div_done) begin
                        state_q <= IDLE;
                        if (fifo_empty) begin
                            underrun_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_mosi   = mosi_q;
    assign dac_ldac_n = ldac_n_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_spi_dac_tx.sv
// tb/tb_spi_dac_tx.sv - scoreboard bench for spi_dac_tx at CLK_DIV=2 and CLK_DIV=1
module tb_spi_dac_tx;

    logic       clk;
    logic       reset;
    logic [1:0] v;
    logic [7:0] d [2];
    logic [1:0] rdy, cs_n, sclk, mosi, ldac_n, busy, und;

    int checks;
    int failures;
    logic [15:0] exp0[$];
    logic [15:0] exp1[$];

    int cyc;
    int last_fall [2];
    int nbits [2];
    int since [2];
    int hi_len [2];
    int ldac_len [2];
    int lat_cnt [2];
    logic [15:0] sh [2];
    logic [1:0] pcs, psck, pldac;

    spi_dac_tx #(.CLK_DIV(2), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .reset(reset), .in_data(d[0]), .in_valid(v[0]), .in_ready(rdy[0]),
        .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]), .dac_mosi(mosi[0]), .dac_ldac_n(ldac_n[0]),
        .busy(busy[0]), .underrun(und[0])
    );

    spi_dac_tx #(.CLK_DIV(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(d[1]), .in_valid(v[1]), .in_ready(rdy[1]),
        .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]), .dac_mosi(mosi[1]), .dac_ldac_n(ldac_n[1]),
        .busy(busy[1]), .underrun(und[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic int divof(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Monitor: reassembles each frame from mosi at sclk rising edges and checks pin timing.
    always @(negedge clk) begin
        logic [15:0] e;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                nbits[i] = 0; since[i] = 0; hi_len[i] = 0; ldac_len[i] = 0;
                pcs[i] = 1'b1; psck[i] = 1'b0; pldac[i] = 1'b1;
            end else begin
                if (pcs[i] && !cs_n[i]) begin
                    if (i == 1 && last_fall[1] >= 0) chk("pop_spacing", cyc - last_fall[1], 36);
                    if (i == 1) last_fall[1] = cyc;
                    nbits[i] = 0; since[i] = 0; sh[i] = '0;
                end else if (!cs_n[i]) begin
                    since[i]++;
                end
                if (!psck[i] && sclk[i]) begin
                    if (nbits[i] == 0) chk("first_sclk_rise", since[i], 2 * divof(i));
                    sh[i] = {sh[i][14:0], mosi[i]};
                    nbits[i]++;
                    hi_len[i] = 1;
                end else if (sclk[i]) begin
                    hi_len[i]++;
                end else if (psck[i] && !sclk[i]) begin
                    chk("sclk_high_len", hi_len[i], divof(i));
                end
                if (!pcs[i] && cs_n[i]) begin
                    chk("frame_bits", nbits[i], 16);
                    if ((i == 0 && exp0.size() == 0) || (i == 1 && exp1.size() == 0)) begin
                        checks++; failures++;
                        $display("FAIL unexpected_frame: dut%0d sent 0x%04h with nothing expected", i, sh[i]);
                    end else begin
                        e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
                        chk(i == 0 ? "frame_dut0" : "frame_dut1", int'(sh[i]), int'(e));
                    end
                end
                if (pldac[i] && !ldac_n[i]) begin
                    lat_cnt[i]++;
                    ldac_len[i] = 1;
                end else if (!ldac_n[i]) begin
                    ldac_len[i]++;
                end else if (!pldac[i] && ldac_n[i]) begin
                    chk("ldac_low_len", ldac_len[i], divof(i));
                end
                pcs[i] = cs_n[i]; psck[i] = sclk[i]; pldac[i] = ldac_n[i];
            end
        end
    end

    task automatic wait_done(input int i);
        bit done = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (((i == 0) ? exp0.size() : exp1.size()) == 0 && !busy[i] && cs_n[i]) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL wait_done: dut%0d still busy after 2000 cycles, got busy=%0d expected 0", i, busy[i]);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_pins(input string tag);
        chk({tag, "_cs_n"}, cs_n[0], 1);
        chk({tag, "_sclk"}, sclk[0], 0);
        chk({tag, "_mosi"}, mosi[0], 0);
        chk({tag, "_ldac_n"}, ldac_n[0], 1);
        chk({tag, "_busy"}, busy[0], 0);
        chk({tag, "_underrun"}, und[0], 0);
        chk({tag, "_in_ready"}, rdy[0], 1);
    endtask

    initial begin
        int lat_before;
        int rises;
        logic ps;
        bit hit;
        checks = 0; failures = 0; cyc = 0;
        last_fall[0] = -1; last_fall[1] = -1;
        lat_cnt[0] = 0; lat_cnt[1] = 0;
        reset = 1'b1; v = 2'b00; d[0] = 8'h00; d[1] = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_pins("por");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("underrun_idle_powerup", und[0], 0);

        // Single sample 0xA5 into an empty FIFO.
        exp0.push_back(16'h3A50);
        v[0] = 1'b1; d[0] = 8'hA5;
        @(negedge clk); v[0] = 1'b0;
        @(negedge clk); chk("cs_n_before_t2", cs_n[0], 1);
        @(negedge clk); chk("cs_n_fall_t2", cs_n[0], 0);
        wait_done(0);
        chk("underrun_after_latch", und[0], 1);

        // Fill while the first frame runs; 0x05 must be refused, then 0x06 lands on the pop.
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("fill_ready", rdy[0], 1);
            d[0] = 8'(k); v[0] = 1'b1;
            exp0.push_back({4'h3, 8'(k), 4'h0});
            @(negedge clk);
        end
        chk("full_refuse", rdy[0], 0);
        d[0] = 8'h05;
        repeat (5) @(negedge clk);
        chk("full_hold", rdy[0], 0);
        d[0] = 8'h06;
        repeat (62) @(negedge clk);
        chk("full_pop_cycle_refuse", rdy[0], 0);
        exp0.push_back(16'h3060);
        @(negedge clk); chk("ready_after_pop", rdy[0], 1);
        @(negedge clk); chk("refull_no_overflow", rdy[0], 0);
        v[0] = 1'b0;
        wait_done(0);

        // Reset during bit 7 of a frame.
        lat_before = lat_cnt[0];
        v[0] = 1'b1; d[0] = 8'h3C;
        @(negedge clk); v[0] = 1'b0;
        rises = 0; ps = 1'b0; hit = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!ps && sclk[0]) rises++;
            ps = sclk[0];
            if (rises == 8) begin hit = 1; break; end
        end
        chk("reached_bit7", int'(hit), 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_pins("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (80) @(negedge clk);
        chk("no_latch_after_reset", lat_cnt[0], lat_before);
        chk("idle_after_reset", busy[0], 0);
        exp0.push_back(16'h3800);
        v[0] = 1'b1; d[0] = 8'h80;
        @(negedge clk); v[0] = 1'b0;
        wait_done(0);
        chk("latch_after_clean_frame", lat_cnt[0], lat_before + 1);
        chk("underrun_after_clean_frame", und[0], 1);

        // CLK_DIV=1 rate check with three queued samples.
        exp1.push_back(16'h3110); chk("rate_ready0", rdy[1], 1); v[1] = 1'b1; d[1] = 8'h11;
        @(negedge clk);
        exp1.push_back(16'h3220); chk("rate_ready1", rdy[1], 1); d[1] = 8'h22;
        @(negedge clk);
        exp1.push_back(16'h3330); chk("rate_ready2", rdy[1], 1); d[1] = 8'h33;
        @(negedge clk);
        v[1] = 1'b0;
        wait_done(1);
        chk("rate_latch_count", lat_cnt[1], 3);
        chk("dut0_queue_drained", exp0.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
